atm_session_ctrl: RTL and testbench

//  Session sequencer for the cash machine. Gates PIN entry with a retry limit and lockout,

---
 rtl/atm_session_ctrl.sv | 172 +++++++++++++++++
 tb/tb_atm_session_ctrl.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/atm_session_ctrl.sv
// ATM session sequencer: PIN gating with retry lockout, menu arbitration,
// paced bill dispensing against an owned balance register, and idle timeout.
module atm_session_ctrl #(
  parameter int unsigned BAL_W     = 3,
  parameter int unsigned BAL_INIT  = 7,
  parameter logic [3:0]  PIN_CODE  = 4'b1001,
  parameter int unsigned MAX_TRIES = 3,
  parameter int unsigned TIMEOUT   = 255,
  parameter int unsigned GAP       = 2,
  parameter int unsigned QUERY_CYC = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             card_in,
  input  logic             pin_valid,
  input  logic [3:0]       pin,
  input  logic             wd_req,
  input  logic [BAL_W-1:0] wd_amt,
  input  logic             query_req,
  input  logic             logout,
  output logic             dispense,
  output logic [BAL_W-1:0] balance,
  output logic [2:0]       state,
  output logic             logged_in,
  output logic             show_balance,
  output logic             locked,
  output logic             pin_bad,
  output logic             wd_reject,
  output logic [1:0]       tries_left
);

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StPin   = 3'd1,
    StMenu  = 3'd2,
    StDisp  = 3'd3,
    StGap   = 3'd4,
    StQuery = 3'd5,
    StLock  = 3'd6
  } state_e;

  localparam logic [BAL_W-1:0] BalInit     = BAL_W'(BAL_INIT);
  localparam logic [BAL_W-1:0] BalOne      = BAL_W'(1);
  localparam logic [1:0]       TriesInit   = 2'(MAX_TRIES);
  localparam logic [7:0]       TimeoutLast = 8'(TIMEOUT - 1);
  localparam logic [7:0]       GapLast     = 8'(GAP - 1);
  localparam logic [7:0]       QueryLast   = 8'(QUERY_CYC - 1);

  state_e           state_q, state_d;
  logic [BAL_W-1:0] balance_q, balance_d;
  logic [BAL_W-1:0] remaining_q, remaining_d;
  logic [1:0]       tries_q, tries_d;
  logic [7:0]       cnt_q, cnt_d;
  logic             pin_bad_q, pin_bad_d;
  logic             wd_reject_q, wd_reject_d;
  logic             cnt_clr;

  // Next-state, balance/tries bookkeeping and one-cycle status pulses.
  always_comb begin
    state_d     = state_q;
    balance_d   = balance_q;
    remaining_d = remaining_q;
    tries_d     = tries_q;
    pin_bad_d   = 1'b0;
    wd_reject_d = 1'b0;
    cnt_clr     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (card_in) state_d = StPin;
      end
      StPin: begin
        if (!card_in) begin
          state_d = StIdle;
        end else if (pin_valid) begin
          cnt_clr = 1'b1;
          if (pin == PIN_CODE) begin
            state_d = StMenu;
            tries_d = TriesInit;
          end else begin
            pin_bad_d = 1'b1;
            tries_d   = tries_q - 2'd1;
            if (tries_q <= 2'd1) state_d = StLock;
          end
        end else if (cnt_q == TimeoutLast) begin
          state_d = StIdle;
        end
      end
      StMenu: begin
        if (!card_in || logout) begin
          state_d = StIdle;
        end else if (wd_req) begin
          cnt_clr = 1'b1;
          // Zero or overdrawing amounts are refused here, so DISP never underflows.
          if (wd_amt == '0 || wd_amt > balance_q) begin
            wd_reject_d = 1'b1;
          end else begin
            remaining_d = wd_amt;
            state_d     = StDisp;
          end
        end else if (query_req) begin
          state_d = StQuery;
        end else if (cnt_q == TimeoutLast) begin
          state_d = StIdle;
        end
      end
      StDisp: begin
        balance_d   = balance_q - BalOne;
        remaining_d = remaining_q - BalOne;
        if (remaining_q == BalOne) state_d = card_in ? StMenu : StIdle;
        else                       state_d = StGap;
      end
      StGap: begin
        if (cnt_q == GapLast) state_d = StDisp;
      end
      StQuery: begin
        if (!card_in)                state_d = StIdle;
        else if (cnt_q == QueryLast) state_d = StMenu;
      end
      StLock: begin
        state_d = StLock;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Shared cycle counter: idle timer in PIN/MENU, pacing in GAP/QUERY.
  always_comb begin
    cnt_d = '0;
    if (!cnt_clr && state_d == state_q &&
        (state_q == StPin || state_q == StMenu || state_q == StGap || state_q == StQuery)) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      balance_q   <= BalInit;
      remaining_q <= '0;
      tries_q     <= TriesInit;
      cnt_q       <= '0;
      pin_bad_q   <= 1'b0;
      wd_reject_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      balance_q   <= balance_d;
      remaining_q <= remaining_d;
      tries_q     <= tries_d;
      cnt_q       <= cnt_d;
      pin_bad_q   <= pin_bad_d;
      wd_reject_q <= wd_reject_d;
    end
  end

  // Moore decode of the state plus registered pulses.
  always_comb begin
    state        = state_q;
    dispense     = (state_q == StDisp);
    logged_in    = (state_q == StMenu) || (state_q == StDisp) ||
                   (state_q == StGap)  || (state_q == StQuery);
    show_balance = (state_q == StQuery);
    locked       = (state_q == StLock);
    balance      = balance_q;
    tries_left   = tries_q;
    pin_bad      = pin_bad_q;
    wd_reject    = wd_reject_q;
  end

endmodule

// File: tb/tb_atm_session_ctrl.sv
// Directed + randomized bench for atm_session_ctrl with a transaction-level balance model.
module tb_atm_session_ctrl;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       card_in = 1'b0;
  logic       pin_valid = 1'b0;
  logic [3:0] pin = 4'd0;
  logic       wd_req = 1'b0;
  logic [2:0] wd_amt = 3'd0;
  logic       query_req = 1'b0;
  logic       logout = 1'b0;
  logic       dispense;
  logic [2:0] balance;
  logic [2:0] state;
  logic       logged_in;
  logic       show_balance;
  logic       locked;
  logic       pin_bad;
  logic       wd_reject;
  logic [1:0] tries_left;

  int checks = 0;
  int errors = 0;
  int m_bal  = 7;

  atm_session_ctrl dut (
    .clock       (clock),
    .reset       (reset),
    .card_in     (card_in),
    .pin_valid   (pin_valid),
    .pin         (pin),
    .wd_req      (wd_req),
    .wd_amt      (wd_amt),
    .query_req   (query_req),
    .logout      (logout),
    .dispense    (dispense),
    .balance     (balance),
    .state       (state),
    .logged_in   (logged_in),
    .show_balance(show_balance),
    .locked      (locked),
    .pin_bad     (pin_bad),
    .wd_reject   (wd_reject),
    .tries_left  (tries_left)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic pin_strobe(input logic [3:0] code);
    pin_valid = 1'b1;
    pin       = code;
    tick();
    pin_valid = 1'b0;
  endtask

  task automatic login();
    pin_strobe(4'b1001);
    chk("login_state", state, 2);
    chk("login_logged_in", logged_in, 1);
    chk("login_tries", tries_left, 3);
  endtask

  // Expected: reject iff amt is 0 or exceeds balance; else amt pulses every 3 cycles.
  task automatic withdraw(input int amt, input bit with_query, input bit drop_card);
    bit rej;
    bit exp_p;
    int pulses;
    int bad;
    rej       = (amt == 0) || (amt > m_bal);
    wd_req    = 1'b1;
    wd_amt    = 3'(amt);
    query_req = with_query;
    tick();
    wd_req    = 1'b0;
    query_req = 1'b0;
    chk("wd_reject", wd_reject, rej);
    pulses = 0;
    bad    = 0;
    for (int i = 0; i < 24; i++) begin
      exp_p = !rej && (i % 3 == 0) && (i / 3 < amt);
      if (dispense !== exp_p) bad++;
      if (dispense === 1'b1) pulses++;
      if (drop_card && i == 1) card_in = 1'b0;
      tick();
    end
    if (!rej) m_bal = m_bal - amt;
    chk("disp_pattern_errs", bad, 0);
    chk("disp_count", pulses, rej ? 0 : amt);
    chk("wd_balance", balance, m_bal);
    chk("wd_end_state", state, drop_card ? 0 : 2);
  endtask

  task automatic do_query();
    int n;
    query_req = 1'b1;
    tick();
    query_req = 1'b0;
    n = 0;
    while (show_balance === 1'b1 && n < 20) begin
      n++;
      tick();
    end
    chk("query_cycles", n, 4);
    chk("query_end_state", state, 2);
    chk("query_balance", balance, m_bal);
  endtask

  initial begin
    int n;
    // Reset values
    tick();
    tick();
    chk("rst_state", state, 0);
    chk("rst_balance", balance, 7);
    chk("rst_tries", tries_left, 3);
    chk("rst_dispense", dispense, 0);
    chk("rst_locked", locked, 0);
    chk("rst_pulses", {pin_bad, wd_reject, logged_in, show_balance}, 0);
    reset = 1'b1;
    tick();
    chk("idle_no_card", state, 0);

    // Card in, correct PIN
    card_in = 1'b1;
    tick();
    chk("pin_state", state, 1);
    login();

    // Withdraw 3 with simultaneous query: withdraw wins
    withdraw(3, 1'b1, 1'b0);
    withdraw(5, 1'b0, 1'b0);
    withdraw(0, 1'b0, 1'b0);
    do_query();

    // Card pulled mid-dispense: all bills still come out, then IDLE
    withdraw(2, 1'b0, 1'b1);
    card_in = 1'b1;
    tick();
    chk("reinsert_state", state, 1);
    login();

    // Asynchronous reset while in GAP
    wd_req = 1'b1;
    wd_amt = 3'd2;
    tick();
    wd_req = 1'b0;
    chk("pre_rst_disp", dispense, 1);
    tick();
    chk("pre_rst_gap", state, 4);
    reset = 1'b0;
    #1;
    chk("async_rst_state", state, 0);
    chk("async_rst_balance", balance, 7);
    chk("async_rst_disp", dispense, 0);
    #2;
    reset = 1'b1;
    m_bal = 7;
    tick();
    chk("post_rst_pin", state, 1);
    login();

    // Randomized withdraw/query traffic against the balance model
    for (int it = 0; it < 8; it++) begin
      if ($urandom_range(0, 2) == 0) do_query();
      withdraw(int'($urandom_range(0, 7)), bit'($urandom_range(0, 1)), 1'b0);
    end

    // Inactivity timeout: a rejected request restarts the idle count
    wd_req = 1'b1;
    wd_amt = 3'd0;
    tick();
    wd_req = 1'b0;
    chk("to_reject", wd_reject, 1);
    n = 0;
    while (state === 3'd2 && n < 400) begin
      n++;
      tick();
    end
    chk("timeout_menu_cycles", n, 255);
    chk("timeout_state", state, 0);
    tick();
    chk("timeout_repin", state, 1);

    // Wrong PIN, card removal does not restore tries, then lockout
    pin_strobe(4'b0010);
    chk("bad1_pulse", pin_bad, 1);
    chk("bad1_tries", tries_left, 2);
    chk("bad1_state", state, 1);
    card_in = 1'b0;
    tick();
    chk("bad1_pulse_clear", pin_bad, 0);
    chk("card_out_idle", state, 0);
    card_in = 1'b1;
    tick();
    chk("tries_kept", tries_left, 2);
    pin_strobe(4'b0010);
    chk("bad2_pulse", pin_bad, 1);
    chk("bad2_tries", tries_left, 1);
    tick();
    pin_strobe(4'b0010);
    chk("bad3_pulse", pin_bad, 1);
    chk("bad3_tries", tries_left, 0);
    chk("lock_state", state, 6);
    chk("locked_flag", locked, 1);
    card_in = 1'b0;
    tick();
    card_in = 1'b1;
    tick();
    pin_strobe(4'b1001);
    tick();
    chk("lock_absorbing", state, 6);
    chk("lock_tries", tries_left, 0);
    chk("lock_balance", balance, m_bal);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
